ballot_controller: RTL
======================

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 10: post-vote lockout length in clock cycles, minimum 1.
REQ-002 Parameter ARM_TIMEOUT, default 1000: cycles an issued ballot stays open before it is cancelled, minimum 1.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  1  0 = voting, 1 = result display; ballots only in mode 0.
REQ-006 ballot_enable  input  1  presiding-officer level; its rising edge issues one ballot.
REQ-007 candidate1_button_press..candidate4_button_press  input  1 each  candidate button levels, already debounced.
REQ-008 ballot_ready  output  1  high while a ballot is open and awaiting a press.
REQ-009 valid_vote_casted  output  1  one-cycle pulse per accepted vote.
REQ-010 vote_rejected  output  1  one-cycle pulse when a multi-button press voids the ballot.
REQ-011 ballot_timeout  output  1  one-cycle pulse when an open ballot expires unused.
REQ-012 candidate1_votes..candidate4_votes  output  4 each  per-candidate tallies.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States are IDLE, ARMED, CAST, LOCKOUT and RELEASE; IDLE is the reset state.
REQ-015 IDLE->ARMED on a rising edge of ballot_enable when mode==0, where the edge is detected against a registered copy of ballot_enable.
REQ-016 A ballot_enable edge seen in any state other than IDLE, or while mode==1, is discarded, and no ballot is queued.
REQ-017 In ARMED, ballot_ready=1 and an arm timer counts up from 0 each cycle.
REQ-018 ARMED, exactly one button high -> CAST, and that candidate index is latched.
REQ-019 ARMED, two or more buttons high in the same cycle -> RELEASE; vote_rejected pulses, and no tally changes.
REQ-020 ARMED, timer reaches ARM_TIMEOUT-1 with no press -> IDLE; ballot_timeout pulses.
REQ-021 ARMED, mode goes to 1 -> IDLE with no pulse; mode takes priority over a press in the same cycle.
REQ-022 CAST lasts one cycle: the latched tally increments, and valid_vote_casted=1 in that cycle.
REQ-023 CAST -> LOCKOUT.
REQ-024 A tally already at 4'hF stays at 4'hF; the vote is still pulsed as valid.
REQ-025 LOCKOUT holds for exactly LOCKOUT_CYCLES cycles, then -> RELEASE; button activity during LOCKOUT is ignored.
REQ-026 RELEASE -> IDLE in the first cycle in which all four buttons are low, so a held button can never cast a second vote.
REQ-027 ballot_ready is registered: it is high from the cycle after entry into ARMED until the cycle after exit from ARMED.
REQ-028 Pulse outputs are never high in the same cycle as each other.
REQ-029 Tallies change only in CAST; mode has no effect on the tallies.

Reset
REQ-030 On reset assertion, asynchronously and regardless of clock: state=IDLE, timers=0, latched index=0, registered ballot_enable=0.
REQ-031 On reset assertion, every output is 0, including all four tallies.
REQ-032 Reset asserted mid-ballot (ARMED, CAST or LOCKOUT) discards that ballot; no tally changes in the reset cycle.
REQ-033 After reset deassertion, a ballot_enable level that is already high does not issue a ballot until it falls and rises again.

Structure
REQ-034 Shared package evm_pkg holds: the state enum, NUM_CANDIDATES=4, VOTE_W=4, and default LOCKOUT_CYCLES/ARM_TIMEOUT constants.
REQ-035 One sub-module, vote_tally: a VOTE_W-bit saturating counter with inc, clock and reset, instantiated four times.
REQ-036 FSM, timers and edge detector stay in ballot_controller.

Verification
REQ-037 Reset, then ballot_enable rise, then candidate2 press -> ballot_ready 1 cycle after the edge; valid_vote_casted one cycle; candidate2_votes=1; others 0.
REQ-038 Candidate1 held for 40 cycles after a vote, LOCKOUT_CYCLES=10 -> exactly one increment; IDLE is reached only after release.
REQ-039 Candidates 1 and 3 pressed in the same ARMED cycle -> vote_rejected pulse; all tallies unchanged.
REQ-040 ARM_TIMEOUT=8 with no press -> ballot_timeout exactly 8 cycles after ARMED entry; state returns to IDLE.
REQ-041 Candidate4 voted 17 times -> candidate4_votes=15; 17 valid_vote_casted pulses.
REQ-042 Reset asserted asynchronously while ARMED, and mode=1 asserted while ARMED in a separate run -> in both cases no vote is counted; state is IDLE; outputs are 0 or unchanged as specified.

Source files
------------

// File: rtl/evm_pkg.sv
// evm_pkg: shared types and constants for the ballot controller.
//   state_e            - controller FSM states
//   NUM_CANDIDATES     - number of candidate buttons / tallies
//   VOTE_W             - tally width in bits
//   *_DEF              - default lockout / ballot-open durations in cycles
package evm_pkg;

   localparam int unsigned NUM_CANDIDATES     = 4;
   localparam int unsigned VOTE_W             = 4;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 10;
   localparam int unsigned ARM_TIMEOUT_DEF    = 1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAST,
      ST_LOCKOUT,
      ST_RELEASE
   } state_e;

   // Index of the lowest set button; only meaningful when exactly one is set.
   function automatic logic [1:0] button_idx(input logic [NUM_CANDIDATES-1:0] b);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = NUM_CANDIDATES; i > 0; i--) begin
         if (b[i-1]) idx = 2'(i - 1);
      end
      return idx;
   endfunction

   // True when two or more buttons are pressed together.
   function automatic logic multi_press(input logic [NUM_CANDIDATES-1:0] b);
      return (b & (b - 1'b1)) != '0;
   endfunction

endpackage

// File: rtl/vote_tally.sv
// vote_tally: saturating per-candidate vote counter.
//   clk     - system clock
//   rst     - asynchronous active-high reset, clears the count
//   inc_i   - add one vote this cycle
//   count_o - current tally, holds at all-ones once full
module vote_tally
   import evm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   output logic [VOTE_W-1:0] count_o
);

   logic [VOTE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: electronic voting machine ballot sequencer.
//   clock, reset                - system clock, asynchronous active-high reset
//   mode                        - 0 = voting, 1 = result display
//   ballot_enable               - presiding-officer level; rising edge issues a ballot
//   candidateN_button_press     - debounced candidate buttons (N = 1..4)
//   ballot_ready                - registered: ballot open and awaiting a press
//   valid_vote_casted           - one-cycle pulse per accepted vote
//   vote_rejected               - one-cycle pulse when a multi-press voids the ballot
//   ballot_timeout              - one-cycle pulse when an open ballot expires
//   candidateN_votes            - saturating per-candidate tallies
//   busy                        - high whenever the FSM is not idle
module ballot_controller
   import evm_pkg::*;
#(
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
   parameter int unsigned ARM_TIMEOUT    = ARM_TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic              ballot_enable,
   input  logic              candidate1_button_press,
   input  logic              candidate2_button_press,
   input  logic              candidate3_button_press,
   input  logic              candidate4_button_press,
   output logic              ballot_ready,
   output logic              valid_vote_casted,
   output logic              vote_rejected,
   output logic              ballot_timeout,
   output logic [VOTE_W-1:0] candidate1_votes,
   output logic [VOTE_W-1:0] candidate2_votes,
   output logic [VOTE_W-1:0] candidate3_votes,
   output logic [VOTE_W-1:0] candidate4_votes,
   output logic              busy
);

   localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);
   localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
   localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

   state_e                    state_q, state_d;
   logic [ARM_W-1:0]          arm_q, arm_d;
   logic [LCK_W-1:0]          lck_q, lck_d;
   logic [1:0]                cand_q, cand_d;
   logic                      en_q;
   logic                      en_low_q, en_low_d;
   logic                      ready_q;
   logic                      valid_q, valid_d;
   logic                      rej_q, rej_d;
   logic                      tmo_q, tmo_d;
   logic [NUM_CANDIDATES-1:0] buttons;
   logic [NUM_CANDIDATES-1:0] inc;
   logic                      en_rise;
   logic [VOTE_W-1:0]         tally [NUM_CANDIDATES];

   assign buttons = {candidate4_button_press, candidate3_button_press,
                     candidate2_button_press, candidate1_button_press};

   // en_low_q blocks a level that was already high across reset release
   // from looking like a fresh edge against the cleared en_q.
   assign en_rise  = ballot_enable && !en_q && en_low_q;
   assign en_low_d = en_low_q || !ballot_enable;

   always_comb begin
      state_d = state_q;
      arm_d   = '0;
      lck_d   = '0;
      cand_d  = cand_q;
      valid_d = 1'b0;
      rej_d   = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_rise && !mode) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            arm_d = arm_q + 1'b1;
            if (mode) begin
               state_d = ST_IDLE;
            end else if (multi_press(buttons)) begin
               state_d = ST_RELEASE;
               rej_d   = 1'b1;
            end else if (buttons != '0) begin
               state_d = ST_CAST;
               cand_d  = button_idx(buttons);
               valid_d = 1'b1;
            end else if (arm_q == ARM_LAST) begin
               state_d = ST_IDLE;
               tmo_d   = 1'b1;
            end
         end
         ST_CAST: begin
            state_d = ST_LOCKOUT;
         end
         ST_LOCKOUT: begin
            if (lck_q == LCK_LAST) state_d = ST_RELEASE;
            else                   lck_d   = lck_q + 1'b1;
         end
         ST_RELEASE: begin
            if (buttons == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pulses are registered on the deciding transition, so each one lines
   // up with the first cycle of the state it leads into.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         arm_q    <= '0;
         lck_q    <= '0;
         cand_q   <= '0;
         en_q     <= 1'b0;
         en_low_q <= 1'b0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         rej_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         arm_q    <= arm_d;
         lck_q    <= lck_d;
         cand_q   <= cand_d;
         en_q     <= ballot_enable;
         en_low_q <= en_low_d;
         ready_q  <= (state_q == ST_ARMED);
         valid_q  <= valid_d;
         rej_q    <= rej_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      inc = '0;
      if (state_q == ST_CAST) inc[cand_q] = 1'b1;
   end

   for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_tally
      vote_tally u_tally (
         .clk     (clock),
         .rst     (reset),
         .inc_i   (inc[g]),
         .count_o (tally[g])
      );
   end

   assign ballot_ready      = ready_q;
   assign valid_vote_casted = valid_q;
   assign vote_rejected     = rej_q;
   assign ballot_timeout    = tmo_q;
   assign busy              = (state_q != ST_IDLE);
   assign candidate1_votes  = tally[0];
   assign candidate2_votes  = tally[1];
   assign candidate3_votes  = tally[2];
   assign candidate4_votes  = tally[3];

endmodule
